gearbox_p2s_stream: RTL and testbench



---
 rtl/gearbox_pkg.sv | 36 +++
 rtl/gearbox_p2s_stream_bitbuf.sv | 60 ++++++
 rtl/gearbox_p2s_stream.sv | 106 ++++++++++
 tb/tb_gearbox_p2s_stream.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gearbox_pkg.sv
// Shared types, width helpers and bit reversal for the parallel-to-serial gearbox.
package gearbox_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } gb_state_t;

    // Widest word bit_rev can handle; IN_W and OUT_W must not exceed this.
    localparam int unsigned REV_MAX = 256;

    // Buffer must hold a not-quite-full output word plus one whole input word.
    function automatic int unsigned gb_buf_w(input int unsigned in_w, input int unsigned out_w);
        return in_w + out_w - 1;
    endfunction

    function automatic int unsigned gb_fill_w(input int unsigned in_w, input int unsigned out_w);
        return $clog2(gb_buf_w(in_w, out_w) + 1);
    endfunction

    // Reverse the low w bits of x; bits above w come back as zero.
    function automatic logic [REV_MAX-1:0] bit_rev(input logic [REV_MAX-1:0] x, input int unsigned w);
        logic [REV_MAX-1:0] src;
        logic [REV_MAX-1:0] r;
        src = x;
        r   = '0;
        for (int unsigned i = 0; i < REV_MAX; i++) begin
            if (i < w) begin
                r   = {r[REV_MAX-2:0], src[0]};
                src = src >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gearbox_p2s_stream_bitbuf.sv
// Bit buffer: drains OUT_W bits from position 0, then appends IN_W bits at the fill point.
module gearbox_bitbuf
    import gearbox_pkg::*;
#(
    parameter int unsigned IN_W   = 130,
    parameter int unsigned OUT_W  = 10,
    parameter int unsigned BUF_W  = gb_buf_w(IN_W, OUT_W),
    parameter int unsigned FILL_W = gb_fill_w(IN_W, OUT_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              append_en,
    input  logic [IN_W-1:0]   din,
    output logic [FILL_W-1:0] fill,
    output logic [OUT_W-1:0]  dout
);

    localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] IN_W_F  = FILL_W'(IN_W);

    logic [BUF_W-1:0]  data_q;
    logic [BUF_W-1:0]  data_sh;
    logic [BUF_W-1:0]  data_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_sh;
    logic [FILL_W-1:0] fill_d;

    // Shift first (saturating at empty for the padded final word), then append.
    // Bits at and above fill are always zero, so appending is a plain OR.
    always_comb begin
        data_sh = data_q;
        fill_sh = fill_q;
        if (shift_en) begin
            data_sh = data_q >> OUT_W;
            fill_sh = (fill_q > OUT_W_F) ? fill_q - OUT_W_F : '0;
        end
        data_d = data_sh;
        fill_d = fill_sh;
        if (append_en) begin
            data_d = data_sh | (BUF_W'(din) << fill_sh);
            fill_d = fill_sh + IN_W_F;
        end
    end

    // Buffer and fill registers; reset discards everything held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            fill_q <= '0;
        end else begin
            data_q <= data_d;
            fill_q <= fill_d;
        end
    end

    assign fill = fill_q;
    assign dout = data_q[OUT_W-1:0];

endmodule

// File: rtl/gearbox_p2s_stream.sv
// Parallel-to-serial gearbox: IN_W-bit words in, OUT_W-bit words out, with flush and bit-order select.
module gearbox_p2s_stream
    import gearbox_pkg::*;
#(
    parameter int unsigned IN_W      = 130,
    parameter int unsigned OUT_W     = 10,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             flush_req,
    output logic [OUT_W-1:0] ser_word,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             flush_done,
    output logic             busy
);

    localparam int unsigned       BUF_W   = gb_buf_w(IN_W, OUT_W);
    localparam int unsigned       FILL_W  = gb_fill_w(IN_W, OUT_W);
    localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);
    localparam logic [OUT_W-1:0]  ONES    = '1;

    gb_state_t         state_q;
    gb_state_t         state_d;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_left;
    logic [OUT_W-1:0]  head;
    logic [OUT_W-1:0]  pad_mask;
    logic [OUT_W-1:0]  word_pad;
    logic [IN_W-1:0]   din_ord;
    logic              ser_fire;
    logic              din_fire;

    // MSB-first mode reverses on entry and exit so the buffer always drains from bit 0.
    assign din_ord  = LSB_FIRST ? din : IN_W'(bit_rev(REV_MAX'(din), IN_W));
    assign ser_fire = ser_valid & ser_ready;
    assign din_fire = din_valid & din_ready;

    gearbox_bitbuf #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .BUF_W  (BUF_W),
        .FILL_W (FILL_W)
    ) u_bitbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (ser_fire),
        .append_en (din_fire),
        .din       (din_ord),
        .fill      (fill),
        .dout      (head)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake decode; din_ready looks ahead at this cycle's drain.
    always_comb begin
        state_d    = state_q;
        ser_valid  = 1'b0;
        ser_last   = 1'b0;
        din_ready  = 1'b0;
        flush_done = 1'b0;
        pad_mask   = ONES;
        fill_left  = fill;
        case (state_q)
            RUN: begin
                ser_valid = (fill >= OUT_W_F);
                fill_left = (ser_valid && ser_ready) ? fill - OUT_W_F : fill;
                din_ready = rst_n && (fill_left < OUT_W_F);
                if (flush_req) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                ser_valid = (fill != '0);
                ser_last  = ser_valid && (fill <= OUT_W_F);
                if (ser_last) begin
                    pad_mask = ~(ONES << fill);
                end
                if (fill == '0) begin
                    flush_done = 1'b1;
                    state_d    = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Zero-pad the final partial word, then restore the requested bit order.
    assign word_pad = head & pad_mask;
    assign ser_word = LSB_FIRST ? word_pad : OUT_W'(bit_rev(REV_MAX'(word_pad), OUT_W));
    assign busy     = (fill != '0) || (state_q == FLUSH);

endmodule

// File: tb/tb_gearbox_p2s_stream.sv
// Directed bench for gearbox_p2s_stream: 130/10 LSB-first, 66/16 flush, 20/10 MSB-first.
module tb_gearbox_p2s_stream;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // DUT A: 130 -> 10, LSB first
    logic [129:0] a_din;
    logic         a_din_valid, a_din_ready, a_flush, a_valid, a_sready, a_last, a_done, a_busy;
    logic [9:0]   a_word;
    // DUT B: 66 -> 16, LSB first
    logic [65:0]  b_din;
    logic         b_din_valid, b_din_ready, b_flush, b_valid, b_sready, b_last, b_done, b_busy;
    logic [15:0]  b_word;
    // DUT C: 20 -> 10, MSB first
    logic [19:0]  c_din;
    logic         c_din_valid, c_din_ready, c_flush, c_valid, c_sready, c_last, c_done, c_busy;
    logic [9:0]   c_word;

    gearbox_p2s_stream #(.IN_W(130), .OUT_W(10), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .din(a_din), .din_valid(a_din_valid), .din_ready(a_din_ready),
        .flush_req(a_flush), .ser_word(a_word), .ser_valid(a_valid), .ser_ready(a_sready),
        .ser_last(a_last), .flush_done(a_done), .busy(a_busy));

    gearbox_p2s_stream #(.IN_W(66), .OUT_W(16), .LSB_FIRST(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
        .flush_req(b_flush), .ser_word(b_word), .ser_valid(b_valid), .ser_ready(b_sready),
        .ser_last(b_last), .flush_done(b_done), .busy(b_busy));

    gearbox_p2s_stream #(.IN_W(20), .OUT_W(10), .LSB_FIRST(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .din(c_din), .din_valid(c_din_valid), .din_ready(c_din_ready),
        .flush_req(c_flush), .ser_word(c_word), .ser_valid(c_valid), .ser_ready(c_sready),
        .ser_last(c_last), .flush_done(c_done), .busy(c_busy));

    int n_tests = 0;
    int n_fail  = 0;

    logic [129:0] da [3];
    logic [65:0]  db [3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Three back-to-back 130-bit words through DUT A, optionally with random ser_ready stalls.
    task automatic run_a(input bit stall, input string name);
        int           in_idx  = 0;
        int           out_idx = 0;
        bit           fi, fo, started, held;
        logic [9:0]   held_w;
        logic [129:0] cur;
        started     = 1'b0;
        held        = 1'b0;
        held_w      = '0;
        a_sready    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        a_din       = da[0];
        a_din_valid = 1'b1;
        for (int cyc = 0; cyc < 400 && out_idx < 39; cyc++) begin
            @(negedge clk);
            fi = a_din_valid && a_din_ready;
            fo = a_valid && a_sready;
            if (held) begin
                check({name, "_hold_word"}, 64'(a_word), 64'(held_w));
                check({name, "_hold_valid"}, 64'(a_valid), 64'd1);
            end
            if (a_valid) begin
                cur = da[out_idx / 13];
                check({name, "_word"}, 64'(a_word), 64'(cur[10*(out_idx % 13) +: 10]));
                check({name, "_last"}, 64'(a_last), 64'd0);
                if (!stall) begin
                    check({name, "_din_ready"}, 64'(a_din_ready), 64'((out_idx % 13) == 12));
                end
                started = 1'b1;
            end else if (started && !stall) begin
                check({name, "_bubble"}, 64'(a_valid), 64'd1);
            end
            held   = a_valid && !a_sready;
            held_w = a_word;
            tick();
            if (fi) in_idx++;
            if (fo) out_idx++;
            a_din_valid = (in_idx < 3);
            if (in_idx < 3) a_din = da[in_idx];
            if (stall) a_sready = 1'($urandom_range(0, 1));
        end
        check({name, "_word_count"}, 64'(out_idx), 64'd39);
        a_sready = 1'b1;
        @(negedge clk);
        check({name, "_idle_busy"}, 64'(a_busy), 64'd0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [207:0] bs;
        int           in_idx, out_idx;
        bit           fi, fo, flushed;

        da[0] = 130'h1_2345_6789_ABCD_EF01_2345_6789_ABCD_EF01;
        da[1] = 130'h2_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
        da[2] = 130'h3_5A5A_5A5A_C3C3_C3C3_0000_FFFF_1234_5678;
        db[0] = 66'h3_0123_4567_89AB_CDEF;
        db[1] = 66'h1_FEDC_BA98_7654_3210;
        db[2] = 66'h2_DEAD_BEEF_CAFE_F00D;

        rst_n = 1'b0;
        a_din = '0; a_din_valid = 1'b0; a_flush = 1'b0; a_sready = 1'b1;
        b_din = '0; b_din_valid = 1'b0; b_flush = 1'b0; b_sready = 1'b1;
        c_din = '0; c_din_valid = 1'b0; c_flush = 1'b0; c_sready = 1'b1;

        // Reset state
        #12;
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_din_ready", 64'(a_din_ready), 64'd0);
        check("rst_word", 64'(a_word), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_last", 64'(a_last), 64'd0);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_b_din_ready", 64'(b_din_ready), 64'd0);
        #10;
        rst_n = 1'b1;
        #1;
        check("post_rst_din_ready", 64'(a_din_ready), 64'd1);
        tick();

        // Full-rate streaming, no stalls
        run_a(1'b0, "stream");

        // Flush with an empty buffer
        a_flush = 1'b1;
        @(negedge clk);
        check("eflush_valid0", 64'(a_valid), 64'd0);
        check("eflush_done0", 64'(a_done), 64'd0);
        tick();
        a_flush = 1'b0;
        @(negedge clk);
        check("eflush_done1", 64'(a_done), 64'd1);
        check("eflush_valid1", 64'(a_valid), 64'd0);
        check("eflush_busy1", 64'(a_busy), 64'd1);
        tick();
        @(negedge clk);
        check("eflush_done2", 64'(a_done), 64'd0);
        check("eflush_busy2", 64'(a_busy), 64'd0);
        tick();

        // Flush together with a din_fire: the whole word drains, last flag on the 13th
        a_din = da[1]; a_din_valid = 1'b1; a_flush = 1'b1;
        @(negedge clk);
        check("dflush_din_ready", 64'(a_din_ready), 64'd1);
        tick();
        a_din_valid = 1'b0; a_flush = 1'b0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            check("dflush_valid", 64'(a_valid), 64'd1);
            check("dflush_word", 64'(a_word), 64'(da[1][10*k +: 10]));
            check("dflush_last", 64'(a_last), 64'(k == 12));
            check("dflush_din_ready", 64'(a_din_ready), 64'd0);
            tick();
        end
        @(negedge clk);
        check("dflush_done", 64'(a_done), 64'd1);
        check("dflush_valid_end", 64'(a_valid), 64'd0);
        tick();
        @(negedge clk);
        check("dflush_done_end", 64'(a_done), 64'd0);
        check("dflush_busy_end", 64'(a_busy), 64'd0);
        tick();

        // Random backpressure
        run_a(1'b1, "stall");

        // 66/16: three words then flush -> 12 full words and one 6-bit padded word
        bs = {10'b0, db[2], db[1], db[0]};
        in_idx = 0; out_idx = 0; flushed = 1'b0;
        b_din = db[0]; b_din_valid = 1'b1;
        for (int cyc = 0; cyc < 100 && out_idx < 13; cyc++) begin
            @(negedge clk);
            fi = b_din_valid && b_din_ready;
            fo = b_valid && b_sready;
            if (b_valid) begin
                check("b_word", 64'(b_word), 64'(bs[16*out_idx +: 16]));
                check("b_last", 64'(b_last), 64'(out_idx == 12));
            end
            tick();
            if (fi) in_idx++;
            if (fo) out_idx++;
            b_flush = 1'b0;
            if (in_idx == 3 && !flushed) begin
                b_flush = 1'b1;
                flushed = 1'b1;
            end
            b_din_valid = (in_idx < 3);
            if (in_idx < 3) b_din = db[in_idx];
        end
        b_flush = 1'b0;
        check("b_word_count", 64'(out_idx), 64'd13);
        @(negedge clk);
        check("b_flush_done", 64'(b_done), 64'd1);
        check("b_valid_end", 64'(b_valid), 64'd0);
        tick();
        @(negedge clk);
        check("b_done_end", 64'(b_done), 64'd0);
        check("b_busy_end", 64'(b_busy), 64'd0);
        tick();

        // MSB-first 20/10
        c_din = 20'hABCDE; c_din_valid = 1'b1;
        @(negedge clk);
        check("c_din_ready", 64'(c_din_ready), 64'd1);
        tick();
        c_din_valid = 1'b0;
        @(negedge clk);
        check("c_valid0", 64'(c_valid), 64'd1);
        check("c_word0", 64'(c_word), 64'(10'b1010101111));
        tick();
        @(negedge clk);
        check("c_valid1", 64'(c_valid), 64'd1);
        check("c_word1", 64'(c_word), 64'(10'b0011011110));
        tick();
        @(negedge clk);
        check("c_valid2", 64'(c_valid), 64'd0);
        tick();

        // Reset with fill=70: six words out of a 130-bit word
        a_sready = 1'b1; a_din = da[2]; a_din_valid = 1'b1;
        tick();
        a_din_valid = 1'b0;
        repeat (6) tick();
        #2;
        check("mid_busy", 64'(a_busy), 64'd1);
        check("mid_word", 64'(a_word), 64'(da[2][60 +: 10]));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(a_valid), 64'd0);
        check("mid_rst_word", 64'(a_word), 64'd0);
        check("mid_rst_din_ready", 64'(a_din_ready), 64'd0);
        check("mid_rst_busy", 64'(a_busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_mid_din_ready", 64'(a_din_ready), 64'd1);
        check("post_mid_valid", 64'(a_valid), 64'd0);
        tick();
        a_din = da[0]; a_din_valid = 1'b1;
        tick();
        a_din_valid = 1'b0;
        @(negedge clk);
        check("post_mid_word0", 64'(a_word), 64'(da[0][9:0]));
        tick();
        @(negedge clk);
        check("post_mid_word1", 64'(a_word), 64'(da[0][19:10]));
        repeat (12) tick();
        @(negedge clk);
        check("post_mid_busy", 64'(a_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
